// File: rtl/rcu_pkg.sv
// rcu_pkg: shared sequencer state type and default parameters for the clock/reset unit
package rcu_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, REL, DONE} seq_state_t;
  localparam int CHNL_NUM_DEF = 4;
  localparam int DIV_WIDTH_DEF = 8;
  localparam int DIV_RST_DEF = 1;
  localparam int RST_DLY_DEF = 4;
endpackage

// File: rtl/rcu_clkdiv_seq_if.sv
// rcu_clkdiv_seq_if: divider ratio handshake, divided clocks and reset-sequencer signals
interface rcu_clkdiv_seq_if import rcu_pkg::*; #(
  parameter int CHNL_NUM = CHNL_NUM_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
);
  logic [CHNL_NUM*DIV_WIDTH-1:0] div_i;
  logic [CHNL_NUM-1:0] div_valid_i, div_ready_o, div_done_o, en_i, clk_trg_o, clk_o, rst_n_o;
  logic seq_start_i, seq_clr_i, seq_busy_o, seq_done_o;
  modport master (
    output div_i, div_valid_i, en_i, seq_start_i, seq_clr_i,
    input div_ready_o, div_done_o, clk_trg_o, clk_o, rst_n_o, seq_busy_o, seq_done_o
  );
  modport slave (
    input div_i, div_valid_i, en_i, seq_start_i, seq_clr_i,
    output div_ready_o, div_done_o, clk_trg_o, clk_o, rst_n_o, seq_busy_o, seq_done_o
  );
endinterface

// File: rtl/rcu_div_chnl.sv
// rcu_div_chnl: one clock divider channel with a single-entry pending ratio update
module rcu_div_chnl import rcu_pkg::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic div_valid_i,
  input  logic en_i,
  output logic div_ready_o,
  output logic div_done_o,
  output logic clk_trg_o,
  output logic clk_o
);
  logic [DIV_WIDTH-1:0] div_q, cnt, pend_val;
  logic pend, apply;
  assign clk_trg_o = en_i && cnt == div_q;
  assign apply = pend && (clk_trg_o || !en_i);
  assign div_ready_o = !pend;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      div_q <= DIV_WIDTH'(DIV_RST);
      cnt <= '0;
      pend_val <= '0;
      pend <= 1'b0;
      clk_o <= 1'b0;
      div_done_o <= 1'b0;
    end else begin
      div_done_o <= apply;
      pend <= apply ? 1'b0 : pend || div_valid_i;
      if (!pend && div_valid_i) pend_val <= div_i;
      if (apply) div_q <= pend_val;
      cnt <= apply || clk_trg_o || !en_i ? '0 : cnt + 1'b1;
      clk_o <= !apply && en_i && (clk_o ^ clk_trg_o);
    end
endmodule

// File: rtl/rcu_clkdiv_seq.sv
// rcu_clkdiv_seq: per-channel clock dividers plus a staggered reset-release sequencer
module rcu_clkdiv_seq import rcu_pkg::*; #(
  parameter int CHNL_NUM = CHNL_NUM_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int RST_DLY = RST_DLY_DEF
) (
  input logic clk_i,
  input logic rst_i,
  rcu_clkdiv_seq_if.slave io
);
  localparam int IDX_W = CHNL_NUM > 1 ? $clog2(CHNL_NUM) : 1;
  localparam int DLY_W = $clog2(RST_DLY + 1);
  logic [CHNL_NUM-1:0] rdy, dn, trg, ck;
  for (genvar k = 0; k < CHNL_NUM; k++) begin : g_chnl
    rcu_div_chnl #(.DIV_WIDTH(DIV_WIDTH), .DIV_RST(DIV_RST)) u_chnl (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .div_i(io.div_i[k*DIV_WIDTH +: DIV_WIDTH]),
      .div_valid_i(io.div_valid_i[k]),
      .en_i(io.en_i[k]),
      .div_ready_o(rdy[k]),
      .div_done_o(dn[k]),
      .clk_trg_o(trg[k]),
      .clk_o(ck[k])
    );
  end
  assign io.div_ready_o = rdy;
  assign io.div_done_o = dn;
  assign io.clk_trg_o = trg;
  assign io.clk_o = ck;
  seq_state_t state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [DLY_W-1:0] dly, dly_nx;
  logic [CHNL_NUM-1:0] rst_n, rst_n_nx;
  logic last;
  assign last = idx == IDX_W'(CHNL_NUM - 1);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      dly <= '0;
      rst_n <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      dly <= dly_nx;
      rst_n <= rst_n_nx;
    end
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    dly_nx = dly;
    rst_n_nx = rst_n;
    if (io.seq_clr_i) begin
      state_nx = IDLE;
      rst_n_nx = '0;
    end else
      case (state)
        IDLE: if (io.seq_start_i) begin
          state_nx = WAIT;
          idx_nx = '0;
          dly_nx = '0;
        end
        WAIT: begin
          dly_nx = dly + 1'b1;
          state_nx = dly == DLY_W'(RST_DLY - 1) ? REL : WAIT;
        end
        REL: begin
          rst_n_nx = rst_n | (CHNL_NUM'(1) << idx);
          dly_nx = '0;
          idx_nx = last ? idx : idx + 1'b1;
          state_nx = last ? DONE : WAIT;
        end
        default: state_nx = state;
      endcase
  end
  assign io.rst_n_o = rst_n;
  assign io.seq_busy_o = state == WAIT || state == REL;
  assign io.seq_done_o = state == DONE;
endmodule

// File: doc/rcu_clkdiv_seq.md
RCU_CLKDIV_SEQ -- requirements
Module: rcu_clkdiv_seq

Interface
REQ-001 SHALL have parameter CHNL_NUM, default 4, number of divided clock/reset channels (1..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 8, width of each channel divide value.
REQ-003 SHALL have parameter DIV_RST, default 1, divide value loaded at reset on every channel.
REQ-004 SHALL have parameter RST_DLY, default 4, cycles between successive reset releases (>=1).
REQ-005 SHALL have clk_i  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have div_i  input  CHNL_NUM*DIV_WIDTH  per-channel divide value, channel k in bits [k*DIV_WIDTH +: DIV_WIDTH].
REQ-008 SHALL have div_valid_i  input  CHNL_NUM  per-channel new-ratio request.
REQ-009 SHALL have div_ready_o  output  CHNL_NUM  per-channel ready to accept a ratio.
REQ-010 SHALL have div_done_o  output  CHNL_NUM  one-cycle pulse, new ratio in effect.
REQ-011 SHALL have en_i  input  CHNL_NUM  per-channel divider enable.
REQ-012 SHALL have clk_trg_o  output  CHNL_NUM  one-cycle strobe at each terminal count.
REQ-013 SHALL have clk_o  output  CHNL_NUM  registered divided clock.
REQ-014 SHALL have seq_start_i  input  1  start reset-release sequence.
REQ-015 SHALL have seq_clr_i  input  1  re-assert all channel resets.
REQ-016 SHALL have rst_n_o  output  CHNL_NUM  per-channel active-low reset, registered.
REQ-017 SHALL have seq_busy_o / seq_done_o  output  1 each  sequencer status levels.

Function
REQ-018 Each channel SHALL count cnt 0..div_q, wrap to 0; clk_trg_o high the cycle cnt==div_q and en_i high.
REQ-019 clk_o SHALL toggle on every clk_trg_o, giving period 2*(div_q+1) cycles; div_q=0 gives clk_i/2.
REQ-020 en_i low SHALL hold cnt at 0, clk_o at 0, clk_trg_o at 0; on en_i rise counting starts at 0 next cycle.
REQ-021 div_ready_o SHALL be high when no ratio is pending; transfer occurs on div_valid_i && div_ready_o.
REQ-022 An accepted value SHALL be held pending (ready low) and applied at the next terminal count, or the next cycle if en_i is low.
REQ-023 On apply, div_q SHALL update, cnt SHALL restart at 0, clk_o SHALL be forced 0, and div_done_o SHALL pulse the following cycle; ready returns high with the done pulse.
REQ-024 div_valid_i while ready is low SHALL be ignored; no queueing beyond one pending value.
REQ-025 Sequencer FSM SHALL have states IDLE, WAIT, REL, DONE.
REQ-026 IDLE + seq_start_i -> WAIT with idx=0, dly counter 0; seq_busy_o high in WAIT and REL.
REQ-027 WAIT SHALL count RST_DLY cycles then -> REL; REL SHALL set rst_n_o[idx]=1, then -> DONE if idx==CHNL_NUM-1, else idx++ and -> WAIT.
REQ-028 DONE SHALL hold all rst_n_o high, seq_done_o high; seq_start_i in DONE or while busy SHALL be ignored.
REQ-029 seq_clr_i in any state SHALL drive all rst_n_o to 0 next cycle and go to IDLE; clr wins over simultaneous start.
REQ-030 Divider channels SHALL run independently of rst_n_o and sequencer state.

Reset
REQ-031 rst_i SHALL set div_q=DIV_RST, cnt=0, pending=0, clk_o=0, clk_trg_o=0, div_done_o=0, div_ready_o=all ones, rst_n_o=0, state=IDLE, seq_busy_o=0, seq_done_o=0.
REQ-032 rst_i mid-sequence or mid-pending SHALL discard progress and pending values with no done pulse.

Structure
REQ-033 FSM state enum and default parameter constants SHALL live in shared package rcu_pkg.
REQ-034 One channel divider SHALL be sub-module rcu_div_chnl, generated CHNL_NUM times; sequencer stays in top.

Verification
REQ-035 Reset, en_i=all ones, DIV_RST=1 -> clk_o period 4 cycles, clk_trg_o every 2 cycles on all channels.
REQ-036 Channel 2 div_i=5 with valid mid-count -> ready drops, applied at next terminal count, div_done_o[2] one pulse, then clk_o period 12.
REQ-037 en_i[1]=0 plus div_i=0 request -> applied next cycle, done pulses, clk_o[1] stays 0 until en_i[1]=1, then period 2.
REQ-038 seq_start_i pulse, RST_DLY=4, CHNL_NUM=4 -> rst_n_o bits rise one at a time, 5 cycles apart; seq_done_o high after fourth.
REQ-039 seq_clr_i with seq_start_i during WAIT after 2 releases -> all rst_n_o 0 next cycle, state IDLE, busy low.
REQ-040 rst_i asserted while channel pending and sequence busy -> all outputs at REQ-031 values next cycle, no div_done_o pulse.
